// File: rtl/multi_ms_timer_if.sv
// Control/status bundle for multi_ms_timer: per-channel command pulses in, count/running/expired out.
interface multi_ms_timer_if #(
  parameter int N_CH = 4,
  parameter int W    = 11
);
  logic [N_CH-1:0]   load;
  logic [W-1:0]      load_value;
  logic [N_CH-1:0]   start;
  logic [N_CH-1:0]   pause;
  logic [N_CH-1:0]   periodic;
  logic [N_CH*W-1:0] count;
  logic [N_CH-1:0]   running;
  logic [N_CH-1:0]   expired;

  modport master (
    output load, load_value, start, pause, periodic,
    input  count, running, expired
  );

  modport slave (
    input  load, load_value, start, pause, periodic,
    output count, running, expired
  );
endinterface

// File: rtl/multi_ms_timer.sv
// N_CH independent ms countdown timers with prescaler, load/start/pause and a 1-cycle expiry pulse.
// Define TIMER_PERIODIC_EN to enable per-channel auto-reload on expiry; otherwise every channel is one-shot.
module multi_ms_timer #(
  parameter int N_CH        = 4,
  parameter int MAX_MS      = 2047,
  parameter int CLKS_PER_MS = 50000
) (
  input  logic           clk,
  input  logic           reset,
  multi_ms_timer_if.slave tif
);
  localparam int W  = $clog2(MAX_MS + 1);
  localparam int PW = $clog2(CLKS_PER_MS);
  localparam logic [PW-1:0] PRE_END = PW'(CLKS_PER_MS - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_e;

  state_e          state_q  [N_CH];
  logic [W-1:0]    count_q  [N_CH];
  logic [W-1:0]    reload_q [N_CH];
  logic [PW-1:0]   pre_q    [N_CH];
  logic [N_CH-1:0] running_q;
  logic [N_CH-1:0] expired_q;

  logic [31:0]     lv_ext;
  logic [W-1:0]    load_d;

  // Shared load value is clamped once; every channel loads the same clamped value.
  assign lv_ext = 32'(tif.load_value);
  assign load_d = (lv_ext > 32'(MAX_MS)) ? W'(MAX_MS) : tif.load_value;

`ifndef TIMER_PERIODIC_EN
  logic [N_CH-1:0] unused_periodic;
  assign unused_periodic = tif.periodic;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i]  <= IDLE;
        count_q[i]  <= '0;
        reload_q[i] <= '0;
        pre_q[i]    <= '0;
      end
      running_q <= '0;
      expired_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        expired_q[i] <= 1'b0;
        if (tif.load[i]) begin
          count_q[i]  <= load_d;
          reload_q[i] <= load_d;
          pre_q[i]    <= '0;
          if (tif.start[i] && !tif.pause[i] && load_d != '0) begin
            state_q[i]   <= RUN;
            running_q[i] <= 1'b1;
          end else begin
            state_q[i]   <= IDLE;
            running_q[i] <= 1'b0;
          end
        end else begin
          unique case (state_q[i])
            RUN: begin
              if (tif.pause[i]) begin
                state_q[i]   <= PAUSED;
                running_q[i] <= 1'b0;
              end else if (pre_q[i] == PRE_END) begin
                pre_q[i] <= '0;
                if (count_q[i] == W'(1)) begin
                  expired_q[i] <= 1'b1;
`ifdef TIMER_PERIODIC_EN
                  if (tif.periodic[i]) begin
                    count_q[i] <= reload_q[i];
                  end else begin
                    count_q[i]   <= '0;
                    state_q[i]   <= DONE;
                    running_q[i] <= 1'b0;
                  end
`else
                  count_q[i]   <= '0;
                  state_q[i]   <= DONE;
                  running_q[i] <= 1'b0;
`endif
                end else begin
                  count_q[i] <= count_q[i] - 1'b1;
                end
              end else begin
                pre_q[i] <= pre_q[i] + 1'b1;
              end
            end
            // Resume from PAUSED keeps the prescaler so the partial ms is preserved.
            IDLE, PAUSED: begin
              if (tif.start[i] && !tif.pause[i] && count_q[i] != '0) begin
                state_q[i]   <= RUN;
                running_q[i] <= 1'b1;
              end
            end
            DONE: begin
              if (tif.start[i] && !tif.pause[i] && reload_q[i] != '0) begin
                count_q[i]   <= reload_q[i];
                pre_q[i]     <= '0;
                state_q[i]   <= RUN;
                running_q[i] <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    tif.count = '0;
    for (int i = 0; i < N_CH; i++) begin
      tif.count[i*W +: W] = count_q[i];
    end
  end

  assign tif.running = running_q;
  assign tif.expired = expired_q;
endmodule

// File: tb/tb_multi_ms_timer.sv
// Randomized + directed bench for multi_ms_timer; reference model tracks remaining clock cycles per channel.
module tb_multi_ms_timer;
  localparam int N = 4;
  localparam int MAXMS = 2047;
  localparam int C = 4;
  localparam int W = 11;
`ifdef TIMER_PERIODIC_EN
  localparam bit PER_EN = 1'b1;
`else
  localparam bit PER_EN = 1'b0;
`endif
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

  logic clk;
  logic reset;
  int n_total;
  int n_bad;

  int   m_mode [N];
  int   m_rem  [N];
  int   m_rel  [N];
  logic m_exp  [N];

  multi_ms_timer_if #(.N_CH(N), .W(W)) tif();

  multi_ms_timer #(.N_CH(N), .MAX_MS(MAXMS), .CLKS_PER_MS(C)) dut (
    .clk  (clk),
    .reset(reset),
    .tif  (tif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: a running channel owns a budget of remaining clock cycles; the visible ms count is its ceiling.
  task automatic model_step(input logic r, input logic [N-1:0] ld, st, ps, per, input logic [W-1:0] lv);
    int v;
    for (int c = 0; c < N; c++) begin
      m_exp[c] = 1'b0;
      if (r) begin
        m_mode[c] = M_IDLE; m_rem[c] = 0; m_rel[c] = 0;
      end else if (ld[c]) begin
        v = (int'(lv) > MAXMS) ? MAXMS : int'(lv);
        m_rem[c] = v * C;
        m_rel[c] = v;
        m_mode[c] = (st[c] && !ps[c] && v != 0) ? M_RUN : M_IDLE;
      end else if (m_mode[c] == M_RUN) begin
        if (ps[c]) m_mode[c] = M_PAUSED;
        else begin
          m_rem[c] = m_rem[c] - 1;
          if (m_rem[c] == 0) begin
            m_exp[c] = 1'b1;
            if (PER_EN && per[c]) m_rem[c] = m_rel[c] * C;
            else m_mode[c] = M_DONE;
          end
        end
      end else if (m_mode[c] == M_DONE) begin
        if (st[c] && !ps[c] && m_rel[c] != 0) begin
          m_rem[c] = m_rel[c] * C;
          m_mode[c] = M_RUN;
        end
      end else if (st[c] && !ps[c] && m_rem[c] != 0) begin
        m_mode[c] = M_RUN;
      end
    end
  endtask

  task automatic compare();
    logic [N*W-1:0] ec;
    logic [N-1:0] er, ee;
    for (int c = 0; c < N; c++) begin
      ec[c*W +: W] = W'((m_rem[c] + C - 1) / C);
      er[c] = (m_mode[c] == M_RUN);
      ee[c] = m_exp[c];
    end
    chk("count", 64'(tif.count), 64'(ec));
    chk("running", 64'(tif.running), 64'(er));
    chk("expired", 64'(tif.expired), 64'(ee));
  endtask

  // Inputs are applied on the falling edge, sampled at the next rising edge, results checked one falling edge later.
  task automatic cyc(input logic r, input logic [N-1:0] ld, st, ps, input logic [W-1:0] lv);
    reset = r;
    tif.load = ld; tif.start = st; tif.pause = ps; tif.load_value = lv;
    @(posedge clk);
    @(negedge clk);
    model_step(r, ld, st, ps, tif.periodic, lv);
    compare();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, '0, '0, '0, '0);
  endtask

  initial begin
    n_total = 0; n_bad = 0;
    reset = 1'b1;
    tif.load = '0; tif.start = '0; tif.pause = '0; tif.periodic = '0; tif.load_value = '0;
    for (int c = 0; c < N; c++) begin
      m_mode[c] = M_IDLE; m_rem[c] = 0; m_rel[c] = 0; m_exp[c] = 1'b0;
    end
    @(negedge clk);
    cyc(1'b1, '0, '0, '0, '0);
    chk("rst_count", 64'(tif.count), 64'd0);
    chk("rst_running", 64'(tif.running), 64'd0);

    // ch0 one-shot of 3 ms
    cyc(1'b0, 4'b0001, 4'b0001, '0, 11'd3);
    chk("ch0_load", 64'(tif.count[0 +: W]), 64'd3);
    idle(4);
    chk("ch0_e4", 64'(tif.count[0 +: W]), 64'd2);
    idle(8);
    chk("ch0_e12_cnt", 64'(tif.count[0 +: W]), 64'd0);
    chk("ch0_e12_exp", 64'(tif.expired[0]), 64'd1);
    chk("ch0_e12_run", 64'(tif.running[0]), 64'd0);
    idle(1);
    chk("ch0_exp_1cyc", 64'(tif.expired[0]), 64'd0);

    // ch1 pause for 20 cycles shifts expiry by 21
    cyc(1'b0, 4'b0010, 4'b0010, '0, 11'd5);
    idle(5);
    cyc(1'b0, '0, '0, 4'b0010, '0);
    idle(19);
    chk("ch1_frozen", 64'(tif.count[W +: W]), 64'd4);
    cyc(1'b0, '0, 4'b0010, '0, '0);
    idle(14);
    chk("ch1_not_yet", 64'(tif.expired[1]), 64'd0);
    idle(1);
    chk("ch1_expiry", 64'(tif.expired[1]), 64'd1);

    // ch2 periodic, then released to one-shot
    tif.periodic = 4'b0100;
    cyc(1'b0, 4'b0100, 4'b0100, '0, 11'd2);
    idle(20);
    tif.periodic = '0;
    idle(20);

    // ch3 zero load with start stays idle; ch0 retrigger from DONE
    cyc(1'b0, 4'b1000, 4'b1000, '0, 11'd0);
    chk("ch3_zero_run", 64'(tif.running[3]), 64'd0);
    idle(3);
    cyc(1'b0, '0, 4'b0001, '0, '0);
    chk("ch0_retrig_cnt", 64'(tif.count[0 +: W]), 64'd3);
    chk("ch0_retrig_run", 64'(tif.running[0]), 64'd1);
    idle(14);

    // reset mid-count
    cyc(1'b0, 4'b0001, 4'b0001, '0, 11'd3);
    idle(5);
    cyc(1'b1, '0, '0, '0, '0);
    chk("midrst_count", 64'(tif.count), 64'd0);
    chk("midrst_run", 64'(tif.running), 64'd0);

    // load on ch1 coincident with ch0 expiry
    cyc(1'b0, 4'b0001, 4'b0001, '0, 11'd1);
    idle(3);
    cyc(1'b0, 4'b0010, '0, '0, 11'd7);
    chk("ch0_exp_vs_ch1_load", 64'(tif.expired[0]), 64'd1);
    idle(3);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic r;
      logic [N-1:0] ld, st, ps;
      logic [W-1:0] lv;
      r = ($urandom_range(0, 399) == 0);
      for (int c = 0; c < N; c++) begin
        ld[c] = ($urandom_range(0, 39) == 0);
        st[c] = ($urandom_range(0, 9) == 0);
        ps[c] = ($urandom_range(0, 29) == 0);
      end
      lv = ($urandom_range(0, 19) == 0) ? W'($urandom_range(0, 2047)) : W'($urandom_range(0, 6));
      if ($urandom_range(0, 99) == 0) tif.periodic = N'($urandom);
      cyc(r, ld, st, ps, lv);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
